// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared digit width and digit helpers for the modulo counters.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Out-of-range digits saturate to the top of the modulus rather than wrap.
  function automatic digit_t clamp_digit(input digit_t val, input int mod);
    if (int'(val) >= mod) begin
      return DIGIT_W'(mod - 1);
    end
    return val;
  endfunction

  function automatic digit_t top_digit(input int mod);
    return DIGIT_W'(mod - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/borrow_down_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : borrow_down_counter_if
// Description : Load / decrement / status bundle of the cascadable down counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface borrow_down_counter_if #(
  parameter int DIGITS = 2
);

  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  bin;
  logic [4*DIGITS-1:0]   q;
  logic                  bout;
  logic                  zero;

  modport master (
    output load,
    output load_val,
    output bin,
    input  q,
    input  bout,
    input  zero
  );

  modport slave (
    input  load,
    input  load_val,
    input  bin,
    output q,
    output bout,
    output zero
  );

endinterface
`default_nettype wire

// File: rtl/down_digit.sv
`default_nettype none
// ============================================================================
// Module      : down_digit
// Description : One modulo-MOD 4-bit down-counting digit with ripple borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module down_digit
  import counter_pkg::*;
#(
  parameter int MOD = 10
) (
  input  wire logic   clock,
  input  wire logic   rst_n,
  input  wire logic   load,
  input  wire digit_t load_val,
  input  wire logic   bin,
  output digit_t      q,
  output digit_t      q_next,
  output logic        bout
);

  digit_t r_q;
  digit_t w_q_next;

  always_comb begin
    w_q_next = r_q;
    if (load) begin
      w_q_next = clamp_digit(load_val, MOD);
    end else if (bin) begin
      w_q_next = (r_q == '0) ? top_digit(MOD) : (r_q - digit_t'(1));
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  // Borrow leaves in the same cycle the digit wraps, so the chain ripples.
  assign bout   = bin & (r_q == '0) & ~load;
  assign q      = r_q;
  assign q_next = w_q_next;

endmodule
`default_nettype wire

// File: rtl/borrow_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : borrow_down_counter
// Description : Cascadable multi-digit modulo down counter with borrow output.
// Revision    : 1.0 - initial release
// ============================================================================
module borrow_down_counter
  import counter_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int MOD          = 10,
  parameter int STOP_AT_ZERO = 0
) (
  input  wire logic              clock,
  input  wire logic              rst_n,
  borrow_down_counter_if.slave   bus
);

  localparam int QW = DIGIT_W * DIGITS;

  logic [DIGITS:0] w_borrow;
  logic [QW-1:0]   w_q;
  logic [QW-1:0]   w_q_next;
  logic            w_all_zero;
  logic            w_hold;
  logic            r_zero;

  assign w_all_zero = (w_q == '0);
  // In hold mode a request at zero never reaches digit 0, so nothing wraps.
  assign w_hold      = (STOP_AT_ZERO != 0) && w_all_zero;
  assign w_borrow[0] = bus.bin & ~w_hold;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      down_digit #(
        .MOD (MOD)
      ) u_digit (
        .clock    (clock),
        .rst_n    (rst_n),
        .load     (bus.load),
        .load_val (bus.load_val[DIGIT_W*i +: DIGIT_W]),
        .bin      (w_borrow[i]),
        .q        (w_q[DIGIT_W*i +: DIGIT_W]),
        .q_next   (w_q_next[DIGIT_W*i +: DIGIT_W]),
        .bout     (w_borrow[i+1])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b1;
    end else begin
      r_zero <= (w_q_next == '0);
    end
  end

  assign bus.q    = w_q;
  assign bus.zero = r_zero;
  assign bus.bout = w_borrow[DIGITS] & ~bus.load & (STOP_AT_ZERO == 0);

endmodule
`default_nettype wire

// File: tb/tb_borrow_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_borrow_down_counter
// Description : Directed bench for wrap-mode and hold-mode 2-digit decimal counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_borrow_down_counter;

  logic clock = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  borrow_down_counter_if #(.DIGITS(2)) bus_w ();
  borrow_down_counter_if #(.DIGITS(2)) bus_h ();

  borrow_down_counter #(.DIGITS(2), .MOD(10), .STOP_AT_ZERO(0)) dut_wrap (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  borrow_down_counter #(.DIGITS(2), .MOD(10), .STOP_AT_ZERO(1)) dut_hold (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus_h)
  );

  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [7:0] val, input logic b);
    bus_w.load = ld; bus_w.load_val = val; bus_w.bin = b;
    bus_h.load = ld; bus_h.load_val = val; bus_h.bin = b;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_both(input string tag, input logic [7:0] qw, input logic zw,
                          input logic [7:0] qh, input logic zh);
    chk({tag, "_q_wrap"}, bus_w.q, qw);
    chk({tag, "_z_wrap"}, bus_w.zero, zw);
    chk({tag, "_q_hold"}, bus_h.q, qh);
    chk({tag, "_z_hold"}, bus_h.zero, zh);
  endtask

  logic [7:0] exp_dec [3];
  logic [7:0] exp_wrap [3];

  initial begin
    exp_dec  = '{8'h24, 8'h23, 8'h22};
    exp_wrap = '{8'h99, 8'h98, 8'h97};

    // Reset
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) step();
    chk_both("rst", 8'h00, 1'b1, 8'h00, 1'b1);
    chk("rst_bout_wrap", bus_w.bout, 1'b0);
    chk("rst_bout_hold", bus_h.bout, 1'b0);
    rst_n = 1'b1;

    // Load then decrement
    drive(1'b1, 8'h25, 1'b0);
    step();
    chk_both("ld25", 8'h25, 1'b0, 8'h25, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("dec_bout_wrap", bus_w.bout, 1'b0);
      chk("dec_bout_hold", bus_h.bout, 1'b0);
      step();
      chk_both("dec", exp_dec[k], 1'b0, exp_dec[k], 1'b0);
    end

    // Borrow ripple across digits
    drive(1'b1, 8'h10, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk_both("ripple", 8'h09, 1'b0, 8'h09, 1'b0);

    // Zero flag follows the decrement into zero with no lag
    drive(1'b1, 8'h01, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk_both("to_zero", 8'h00, 1'b1, 8'h00, 1'b1);

    // Underflow: wrap versus hold
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("uf_bout_wrap", bus_w.bout, (k == 0) ? 1'b1 : 1'b0);
      chk("uf_bout_hold", bus_h.bout, 1'b0);
      step();
      chk_both("uf", exp_wrap[k], 1'b0, 8'h00, 1'b1);
    end

    // load and bin together at zero: load wins, no borrow
    drive(1'b1, 8'h00, 1'b0);
    step();
    drive(1'b1, 8'h3C, 1'b1);
    #1;
    chk("ldbin_bout_wrap", bus_w.bout, 1'b0);
    chk("ldbin_bout_hold", bus_h.bout, 1'b0);
    step();
    chk_both("ld3c", 8'h39, 1'b0, 8'h39, 1'b0);

    // Clamp both digits, bin ignored
    drive(1'b1, 8'hAF, 1'b1);
    step();
    chk_both("ldaf", 8'h99, 1'b0, 8'h99, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk_both("after_clamp", 8'h98, 1'b0, 8'h98, 1'b0);

    // Asynchronous reset between edges
    drive(1'b0, 8'h00, 1'b0);
    #5;
    rst_n = 1'b0;
    #1;
    chk_both("async_rst", 8'h00, 1'b1, 8'h00, 1'b1);
    #2;
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    #1;
    chk("post_rst_bout_wrap", bus_w.bout, 1'b1);
    chk("post_rst_bout_hold", bus_h.bout, 1'b0);
    step();
    chk_both("post_rst", 8'h99, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    step();
    chk_both("idle", 8'h99, 1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
